// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access sequencer.
//   - op-code constants for the six legal load/store operations
//   - FSM state encoding
//   - decode helpers used by the top level
package mem_access_pkg;

    localparam logic [2:0] LW = 3'b000;
    localparam logic [2:0] LH = 3'b001;
    localparam logic [2:0] LB = 3'b010;
    localparam logic [2:0] SW = 3'b100;
    localparam logic [2:0] SH = 3'b101;
    localparam logic [2:0] SB = 3'b110;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    function automatic logic is_store(input logic [2:0] op);
        return op[2];
    endfunction

    // Illegal op codes and misaligned word/half accesses are rejected
    // before any memory activity.
    function automatic logic is_bad(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            LW, SW:  bad = (off != 2'b00);
            LH, SH:  bad = off[0];
            LB, SB:  bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic for sub-word accesses (little-endian).
//   op        : latched operation code
//   off       : byte offset addr[1:0]
//   rword     : word read from memory
//   wdata     : low half of the store data (SB uses [7:0], SH uses [15:0])
//   load_val  : LB/LH sign-extended lane, LW passes rword through
//   merge_val : rword with the SB byte / SH half replaced by store data
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] rword,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merge_val
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rword[{off, 3'b000} +: 8];
        lane_h = rword[{off[1], 4'b0000} +: 16];

        case (op)
            LB:      load_val = {{24{lane_b[7]}}, lane_b};
            LH:      load_val = {{16{lane_h[15]}}, lane_h};
            default: load_val = rword;
        endcase

        merge_val = rword;
        case (op)
            SB:      merge_val[{off, 3'b000} +: 8]     = wdata[7:0];
            SH:      merge_val[{off[1], 4'b0000} +: 16] = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer between the control unit and a 32-bit
// word-wide data memory with fixed read latency MEM_LAT.
//   clock, reset(async, active low)
//   req/op/addr/wdata : single-cycle request, sampled only in IDLE
//   busy              : transaction in flight (RD, WR or RESP)
//   done/err/rdata    : completion pulse, error flag, load result
//   mem_addr/mem_wr/mem_wdata/mem_rdata : memory port
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [31:0]        addr_q;
    logic [15:0]        wdata_q;
    logic               err_q;
    logic               bad;
    logic [31:0]        load_val, merge_val;

    assign bad = is_bad(op, addr[1:0]);

    byte_lane_unit u_lane (
        .op        (op_q),
        .off       (addr_q[1:0]),
        .rword     (mem_rdata),
        .wdata     (wdata_q),
        .load_val  (load_val),
        .merge_val (merge_val)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = bad ? RESP : ((op == SW) ? WR : RD);
            RD:   if (cnt == '0) state_nxt = is_store(op_q) ? WR : RESP;
            WR:   state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    op_q    <= op;
                    addr_q  <= addr;
                    wdata_q <= wdata[15:0];
                    err_q   <= bad;
                    cnt     <= CNT_W'(MEM_LAT - 1);
                    if (op == SW) mem_wdata <= wdata;
                end
                RD: begin
                    // mem_rdata is valid on the last RD cycle; the lane unit
                    // works on it directly so no separate capture register is needed.
                    if (cnt == '0) begin
                        if (is_store(op_q)) mem_wdata <= merge_val;
                        else                rdata     <= load_val;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state, so reset clears them at once.
    assign busy     = (state != IDLE);
    assign done     = (state == RESP);
    assign err      = done & err_q;
    assign mem_wr   = (state == WR);
    assign mem_addr = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        busy, done, err, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad = 0;

    mem_access_ctrl #(.MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory responder: one register stage gives data MEM_LAT=2 cycles after
    // the address appears.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q = 32'h0;
    always @(posedge clock) begin
        if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
        rd_q <= mem[mem_addr[9:2]];
    end
    assign mem_rdata = rd_q;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rdata = 32'h0;

    task automatic poke(input int idx, input logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] r, output logic e,
                         output int wrs, output logic [31:0] wd);
        logic [31:0] w, v, mask;
        int unsigned k;
        w = ref_mem[a[9:2]];
        k = a % 4;
        e = !(o inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) ||
            ((o == 3'd0 || o == 3'd4) && (a % 4 != 0)) ||
            ((o == 3'd1 || o == 3'd5) && (a % 2 != 0));
        wrs = 0;
        wd = 32'h0;
        lat = 1;
        if (!e) begin
            case (o)
                3'd0: begin lat = LAT + 1; exp_rdata = w; end
                3'd1: begin
                    lat = LAT + 1;
                    v = (w >> (16 * (k / 2))) & 32'hFFFF;
                    exp_rdata = (v >= 32'h8000) ? v - 32'h10000 : v;
                end
                3'd2: begin
                    lat = LAT + 1;
                    v = (w >> (8 * k)) & 32'hFF;
                    exp_rdata = (v >= 32'h80) ? v - 32'h100 : v;
                end
                3'd4: begin lat = 2; wrs = 1; wd = d; end
                3'd5: begin
                    lat = LAT + 2; wrs = 1;
                    mask = 32'hFFFF << (16 * (k / 2));
                    wd = (w & ~mask) | ((d & 32'hFFFF) << (16 * (k / 2)));
                end
                default: begin
                    lat = LAT + 2; wrs = 1;
                    mask = 32'hFF << (8 * k);
                    wd = (w & ~mask) | ((d & 32'hFF) << (8 * k));
                end
            endcase
        end
        if (wrs != 0) ref_mem[a[9:2]] = wd;
        r = exp_rdata;
    endtask

    // Drives one request and observes the DUT until done (bounded).
    // hold_req keeps req high with a conflicting SW while busy.
    task automatic run_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                           input bit hold_req, output int lat, output logic [31:0] r,
                           output logic e, output int wrs, output logic [31:0] wd,
                           output logic [31:0] wa, output logic [31:0] ra, output logic b1);
        @(negedge clock);
        req = 1'b1; op = o; addr = a; wdata = d;
        @(posedge clock);
        #1;
        if (hold_req) begin op = 3'd4; addr = 32'h3FC; wdata = 32'hA5A5A5A5; end
        else req = 1'b0;
        lat = 0; wrs = 0; wd = 32'h0; wa = 32'h0; b1 = 1'b0;
        forever begin
            @(negedge clock);
            lat++;
            if (lat == 1) b1 = busy;
            if (mem_wr) begin wrs++; wd = mem_wdata; wa = mem_addr; end
            if (done || lat >= 40) break;
        end
        r = rdata; e = err; ra = mem_addr;
        req = 1'b0;
    endtask

    task automatic test_reset();
        #17;
        total++;
        if ({busy, done, err, mem_wr} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {busy, done, err, mem_wr});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
            bad++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rdata);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_lw();
        int lat, wrs, mlat, mwrs; logic [31:0] r, wd, wa, ra, mr, mwd; logic e, b1, me;
        poke(32'h40 >> 2, 32'hDEADBEEF);
        model(3'd0, 32'h40, 32'h0, mlat, mr, me, mwrs, mwd);
        run_txn(3'd0, 32'h40, 32'h0, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h want=deadbeef", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL lw_err got=%b want=0", e); end
        total++; if (lat != 3) begin bad++; $display("FAIL lw_latency got=%0d want=3", lat); end
        total++; if (wrs != 0) begin bad++; $display("FAIL lw_memwr got=%0d want=0", wrs); end
        total++; if (b1 !== 1'b1 || ra !== 32'h0) begin
            bad++; $display("FAIL lw_busy_addr busy=%b resp_addr=%h want 1/0", b1, ra);
        end
    endtask

    task automatic test_lb_lh();
        int lat, wrs, mlat, mwrs; logic [31:0] r, wd, wa, ra, mr, mwd; logic e, b1, me;
        poke(32'h40 >> 2, 32'h80112233);
        model(3'd2, 32'h43, 32'h0, mlat, mr, me, mwrs, mwd);
        run_txn(3'd2, 32'h43, 32'h0, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (r !== 32'hFFFFFF80 || lat != 3) begin
            bad++; $display("FAIL lb_sext got=%h lat=%0d want=ffffff80 lat=3", r, lat);
        end
        model(3'd1, 32'h42, 32'h0, mlat, mr, me, mwrs, mwd);
        run_txn(3'd1, 32'h42, 32'h0, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (r !== 32'hFFFF8011 || e !== 1'b0) begin
            bad++; $display("FAIL lh_sext got=%h err=%b want=ffff8011 err=0", r, e);
        end
    endtask

    task automatic test_sb();
        int lat, wrs, mlat, mwrs; logic [31:0] r, wd, wa, ra, mr, mwd; logic e, b1, me;
        poke(32'h40 >> 2, 32'h11223344);
        model(3'd6, 32'h41, 32'hAA, mlat, mr, me, mwrs, mwd);
        run_txn(3'd6, 32'h41, 32'h000000AA, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (wrs != 1 || wd !== 32'h1122AA44 || wa !== 32'h40) begin
            bad++; $display("FAIL sb_merge wrs=%0d data=%h addr=%h want 1/1122aa44/40", wrs, wd, wa);
        end
        total++; if (lat != 4 || e !== 1'b0) begin
            bad++; $display("FAIL sb_latency got=%0d err=%b want=4 err=0", lat, e);
        end
        @(negedge clock);
        total++; if (mem[32'h40 >> 2] !== 32'h1122AA44) begin
            bad++; $display("FAIL sb_memword got=%h want=1122aa44", mem[32'h40 >> 2]);
        end
    endtask

    task automatic test_errors();
        int lat, wrs, mlat, mwrs; logic [31:0] r, wd, wa, ra, mr, mwd, prev; logic e, b1, me;
        prev = exp_rdata;
        model(3'd4, 32'h42, 32'h55, mlat, mr, me, mwrs, mwd);
        run_txn(3'd4, 32'h42, 32'h55, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (lat != 1 || e !== 1'b1 || wrs != 0 || r !== prev) begin
            bad++; $display("FAIL sw_misalign lat=%0d err=%b wrs=%0d rdata=%h want 1/1/0/%h", lat, e, wrs, r, prev);
        end
        model(3'd3, 32'h40, 32'h0, mlat, mr, me, mwrs, mwd);
        run_txn(3'd3, 32'h40, 32'h0, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (lat != 1 || e !== 1'b1 || wrs != 0 || r !== prev) begin
            bad++; $display("FAIL op011 lat=%0d err=%b wrs=%0d rdata=%h want 1/1/0/%h", lat, e, wrs, r, prev);
        end
    endtask

    task automatic test_back_to_back();
        int lat, wrs, mlat, mwrs; logic [31:0] r, wd, wa, ra, mr, mwd; logic e, b1, me;
        model(3'd4, 32'h80, 32'h12345678, mlat, mr, me, mwrs, mwd);
        run_txn(3'd4, 32'h80, 32'h12345678, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (wrs != 1 || wd !== 32'h12345678 || lat != 2) begin
            bad++; $display("FAIL b2b_sw wrs=%0d data=%h lat=%0d want 1/12345678/2", wrs, wd, lat);
        end
        model(3'd0, 32'h80, 32'h0, mlat, mr, me, mwrs, mwd);
        run_txn(3'd0, 32'h80, 32'h0, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (r !== 32'h12345678 || lat != 3) begin
            bad++; $display("FAIL b2b_lw got=%h lat=%0d want=12345678 lat=3", r, lat);
        end
    endtask

    task automatic test_req_while_busy();
        int lat, wrs, mlat, mwrs; logic [31:0] r, wd, wa, ra, mr, mwd; logic e, b1, me;
        model(3'd0, 32'h80, 32'h0, mlat, mr, me, mwrs, mwd);
        run_txn(3'd0, 32'h80, 32'h0, 1'b1, lat, r, e, wrs, wd, wa, ra, b1);
        @(negedge clock);
        total++; if (wrs != 0 || busy !== 1'b0 || r !== mr) begin
            bad++; $display("FAIL busy_req wrs=%0d busy_after=%b rdata=%h want 0/0/%h", wrs, busy, r, mr);
        end
    endtask

    task automatic test_reset_mid_wr();
        int lat, wrs, mlat, mwrs, n; logic [31:0] r, wd, wa, ra, mr, mwd; logic e, b1, me;
        poke(32'h100 >> 2, 32'hCAFE1234);
        @(negedge clock);
        req = 1'b1; op = 3'd5; addr = 32'h102; wdata = 32'h0000BEEF;
        @(posedge clock);
        #1 req = 1'b0;
        n = 0;
        while (mem_wr !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL rst_wr_reach mem_wr=%b want=1", mem_wr); end
        #2 reset = 1'b0;
        #1;
        total++; if ({busy, done, err, mem_wr} !== 4'b0 || mem_addr !== 32'h0 ||
                     mem_wdata !== 32'h0 || rdata !== 32'h0) begin
            bad++; $display("FAIL rst_async ctrl=%b addr=%h wdata=%h rdata=%h want all 0",
                            {busy, done, err, mem_wr}, mem_addr, mem_wdata, rdata);
        end
        @(posedge clock);
        @(negedge clock);
        total++; if (mem[32'h100 >> 2] !== 32'hCAFE1234) begin
            bad++; $display("FAIL rst_nowrite got=%h want=cafe1234", mem[32'h100 >> 2]);
        end
        reset = 1'b1;
        exp_rdata = 32'h0;
        model(3'd0, 32'h100, 32'h0, mlat, mr, me, mwrs, mwd);
        run_txn(3'd0, 32'h100, 32'h0, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
        total++; if (r !== 32'hCAFE1234 || lat != 3 || e !== 1'b0) begin
            bad++; $display("FAIL rst_recover got=%h lat=%0d err=%b want=cafe1234/3/0", r, lat, e);
        end
    endtask

    task automatic test_random();
        int lat, wrs, mlat, mwrs; logic [31:0] r, wd, wa, ra, mr, mwd, a, d; logic e, b1, me;
        logic [2:0] o;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            d = $urandom;
            model(o, a, d, mlat, mr, me, mwrs, mwd);
            run_txn(o, a, d, 1'b0, lat, r, e, wrs, wd, wa, ra, b1);
            total++;
            if (lat != mlat || e !== me || r !== mr || wrs != mwrs ||
                (mwrs != 0 && (wd !== mwd || wa !== {a[31:2], 2'b00}))) begin
                bad++;
                $display("FAIL rand[%0d] op=%0d addr=%h got lat=%0d err=%b rdata=%h wrs=%0d wd=%h wa=%h want lat=%0d err=%b rdata=%h wrs=%0d wd=%h",
                         i, o, a, lat, e, r, wrs, wd, wa, mlat, me, mr, mwrs, mwd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) poke(i, $urandom);
        test_reset();
        test_lw();
        test_lb_lh();
        test_sb();
        test_errors();
        test_back_to_back();
        test_req_while_busy();
        test_reset_mid_wr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multicycle data-memory access sequencer between the control unit and the 32-bit word-wide data memory. The control unit issues one load/store request (word, half or byte) with a single-cycle handshake. The block then drives the memory address and write-enable, waits out the fixed read latency, and performs lane extraction with sign extension or a read-modify-write merge. It reports completion with a one-cycle `done` pulse and flags misaligned or illegal requests.

## Interface
- `MEM_LAT`, default 2: memory read latency in cycles. Legal range 1–15.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: request strobe; sampled only in IDLE.
- `op` in 3: operation code. 000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB; all other codes are illegal.
- `addr` in 32: byte address.
- `wdata` in 32: store data; the low byte or half is used for SB and SH.
- `busy` out 1: high from the cycle after accept through the RESP cycle.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`. High for misaligned or illegal requests.
- `rdata` out 32: load result, valid with `done`; held until the next `done`.
- `mem_addr` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `mem_wr` out 1: memory write enable.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid `MEM_LAT` cycles after `mem_addr` is stable.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE, `req`=1: latch `op`, `addr` and `wdata`, then decode.
  - Illegal op, LW/SW with `addr[1:0]`≠0, or LH/SH with `addr[0]`≠0: go to RESP with `err`=1. No memory activity.
  - SW goes to WR with `mem_wdata`=`wdata`.
  - LW, LH, LB, SH and SB go to RD.
- RD:
  - `mem_addr` is driven; the wait counter loads `MEM_LAT-1` on entry and decrements each cycle.
  - At zero, capture `mem_rdata`.
  - Loads go to RESP. SH and SB go to WR with the merged word.
- Byte order is little-endian: byte k of a word occupies bits [8k+7:8k], with k=`addr[1:0]`; halfword h=`addr[1]` occupies bits [16h+15:16h].
- LB and LH sign-extend to 32 bits; LW passes the word unmodified.
- The SB merge replaces byte k with `wdata[7:0]`; the SH merge replaces half h with `wdata[15:0]`. All other bits keep the captured read value.
- WR: `mem_wr`=1 for exactly one cycle, then go to RESP.
- RESP: `done`=1 for one cycle, `err` as decided, `rdata` updated for loads only. Then return to IDLE.
- `req` outside IDLE (including during RESP) is ignored. There is no queueing; the requester re-asserts after `done`.

## Timing
- Latency counts from the accept edge (the edge sampling `req` in IDLE):
  - Error: `done` in the first cycle after accept.
  - SW: `done` 2 cycles after accept (WR, then RESP).
  - Loads: `done` `MEM_LAT`+1 cycles after accept.
  - SH/SB: `done` `MEM_LAT`+2 cycles after accept.
- `mem_addr` is held stable from RD/WR entry through WR. It is 0 in IDLE and RESP.
- `mem_wr` is registered, never combinational from `req`. It is never high outside WR.
- Back-to-back operation: a request may be accepted in the first IDLE cycle after RESP, so the minimum spacing is one IDLE cycle between transactions.
- Reset (`reset`=0):
  - Effect is immediate and asynchronous: state IDLE, counter 0.
  - `busy`, `done`, `err`, `mem_wr`, `mem_addr`, `mem_wdata` and `rdata` all go to 0.
  - Reset mid-transaction abandons it; a reset during WR deasserts `mem_wr` at once, so no partial write completes after reset.

## Structure
- Package `mem_access_pkg`: op-code constants (LW, LH, LB, SW, SH, SB), state encoding (IDLE, RD, WR, RESP), and an `is_store` helper.
- Sub-module `byte_lane_unit`: purely combinational. It implements the load extract/sign-extend and the store merge from (op, `addr[1:0]`, read word, `wdata`).
- The top level holds the FSM, wait counter and request latches.

## Test plan
- LW, `addr`=0x40, memory[0x40]=0xDEADBEEF, `MEM_LAT`=2:
  - `rdata`=0xDEADBEEF, `err`=0.
  - `done` 3 cycles after accept.
  - `mem_wr` never asserted.
- LB at 0x43 on word 0x80112233: `rdata`=0xFFFFFF80. LH at 0x42 on the same word: `rdata`=0xFFFF8011.
- SB, `addr`=0x41, `wdata`=0x000000AA, old word 0x11223344:
  - single `mem_wr` pulse with `mem_wdata`=0x1122AA44.
  - `done` at accept+4.
- SW, `addr`=0x42: `done`+`err` at accept+1, no `mem_wr`, `rdata` unchanged. Op 011 behaves identically.
- SW 0x12345678 to 0x80, immediately followed by LW 0x80:
  - `mem_wr` for exactly 1 cycle.
  - The LW is accepted one IDLE cycle after the SW's RESP and returns 0x12345678.
- Reset mid-SH during WR:
  - `mem_wr` falls in the same cycle and all outputs go to 0.
  - After release, a new LW completes normally.
  - A `req` asserted while `busy` is never accepted.
